// File: rtl/soc_chip_top_if.sv
// Board-facing serial pins of the bring-up chip: host UART, trace UART and SPI.
`timescale 1ns/1ps
interface soc_chip_top_if;
   logic rxd;
   logic txd;
   logic trace_rxd;
   logic trace_txd;
   logic spi_cs;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_miso;

   // Chip side
   modport slave (
      input  rxd, trace_rxd, spi_miso,
      output txd, trace_txd, spi_cs, spi_sclk, spi_mosi
   );

   // Board / host side
   modport master (
      output rxd, trace_rxd, spi_miso,
      input  txd, trace_txd, spi_cs, spi_sclk, spi_mosi
   );
endinterface

// File: rtl/soc_chip_top.sv
// Bring-up chip top: reset synchroniser, host UART echo, one SPI transfer per
// accepted byte, MISO byte and a boot byte reported on the trace UART.
`timescale 1ns/1ps
module soc_chip_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 1736
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [7:0] data,
   output logic       txd,
   output logic       busy
);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic          txd_q, txd_d;

   // 8N1 frame sequencer; txd is registered so the start bit follows req by one cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      txd_d   = txd_q;
      case (state_q)
         TX_IDLE: begin
            if (req) begin
               state_d = TX_START;
               cnt_d   = CW'(CLKS_PER_BIT - 1);
               sh_d    = data;
               txd_d   = 1'b0;
            end
         end
         TX_START, TX_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = CW'(CLKS_PER_BIT - 1);
               if (state_q == TX_DATA && idx_q == 3'd7) begin
                  state_d = TX_STOP;
                  txd_d   = 1'b1;
               end else begin
                  idx_d   = (state_q == TX_START) ? 3'd0 : idx_q + 3'd1;
                  state_d = TX_DATA;
                  txd_d   = sh_q[0];
                  sh_d    = {1'b0, sh_q[7:1]};
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         TX_STOP: begin
            if (cnt_q == '0) state_d = TX_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // Transmitter state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         txd_q   <= txd_d;
      end
   end

   assign txd  = txd_q;
   assign busy = (state_q != TX_IDLE);
endmodule

module soc_chip_top #(
   parameter int unsigned CLKS_PER_BIT = 1736,
   parameter int unsigned SPI_HALF     = 4,
   parameter logic [7:0]  BOOT_BYTE    = 8'hA5
) (
   input logic           clk_p,
   input logic           clk_n,
   input logic           rst_top,
   soc_chip_top_if.slave io
);
   localparam int unsigned CW  = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned SCW = $clog2(SPI_HALF + 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
   typedef enum logic [2:0] {SPI_IDLE, SPI_ASSERT, SPI_HIGH, SPI_LOW, SPI_DEASSERT} spi_state_e;

   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;
   logic [1:0] rxd_sync_q, rxd_sync_d;
   logic       rx;

   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    rx_sh_q, rx_sh_d;

   spi_state_e     spi_state_q, spi_state_d;
   logic [SCW-1:0] spi_cnt_q, spi_cnt_d;
   logic [2:0]     spi_bit_q, spi_bit_d;
   logic [7:0]     mosi_sh_q, mosi_sh_d;
   logic [7:0]     miso_sh_q, miso_sh_d;
   logic           cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;

   logic boot_pend_q, boot_pend_d;
   logic rx_ok, accept, spi_busy, spi_done;
   logic tx_busy, tx_txd, trace_busy, trace_txd, trace_req;
   logic [7:0] trace_data;
   logic unused_inputs;

   assign unused_inputs = clk_n ^ io.trace_rxd;

   // Release of the board reset is synchronised; assertion stays asynchronous
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   // Reset synchroniser flops
   always_ff @(posedge clk_p or negedge rst_top) begin
      if (!rst_top) rst_sync_q <= '0;
      else          rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   // Host RX line synchroniser input
   always_comb rxd_sync_d = {rxd_sync_q[0], io.rxd};

   // Host RX line synchroniser flops (idle high)
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) rxd_sync_q <= '1;
      else        rxd_sync_q <= rxd_sync_d;
   end

   assign rx = rxd_sync_q[1];

   // UART receiver: mid-bit sampling, glitch reject on start, stall on framing error
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_sh_d    = rx_sh_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx) begin
               rx_state_d = RX_START;
               rx_cnt_d   = CW'(CLKS_PER_BIT / 2 - 1);
            end
         end
         RX_START: begin
            if (rx_cnt_q == '0) begin
               if (rx) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = CW'(CLKS_PER_BIT - 1);
                  rx_idx_d   = '0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_sh_d  = {rx, rx_sh_q[7:1]};
               rx_cnt_d = CW'(CLKS_PER_BIT - 1);
               if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_idx_d   = rx_idx_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == '0) rx_state_d = rx ? RX_IDLE : RX_WAIT;
            else                rx_cnt_d   = rx_cnt_q - 1'b1;
         end
         RX_WAIT: begin
            if (rx) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Receiver state registers
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_sh_q    <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_sh_q    <= rx_sh_d;
      end
   end

   // A good stop bit yields a byte; it is kept only if every consumer is free
   assign rx_ok    = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx;
   assign spi_busy = (spi_state_q != SPI_IDLE);
   assign spi_done = (spi_state_q == SPI_DEASSERT) && (spi_cnt_q == '0);
   assign accept   = rx_ok && !tx_busy && !spi_busy && !trace_busy && !boot_pend_q;

   // SPI mode-0 master: MISO captured on the same clk_p edge that raises SCLK
   always_comb begin
      spi_state_d = spi_state_q;
      spi_cnt_d   = spi_cnt_q;
      spi_bit_d   = spi_bit_q;
      mosi_sh_d   = mosi_sh_q;
      miso_sh_d   = miso_sh_q;
      cs_d        = cs_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      case (spi_state_q)
         SPI_IDLE: begin
            if (accept) begin
               spi_state_d = SPI_ASSERT;
               spi_cnt_d   = SCW'(SPI_HALF - 1);
               spi_bit_d   = '0;
               cs_d        = 1'b0;
               mosi_d      = rx_sh_q[7];
               mosi_sh_d   = {rx_sh_q[6:0], 1'b0};
            end
         end
         SPI_ASSERT, SPI_LOW: begin
            if (spi_cnt_q == '0) begin
               spi_state_d = SPI_HIGH;
               spi_cnt_d   = SCW'(SPI_HALF - 1);
               sclk_d      = 1'b1;
               miso_sh_d   = {miso_sh_q[6:0], io.spi_miso};
            end else begin
               spi_cnt_d = spi_cnt_q - 1'b1;
            end
         end
         SPI_HIGH: begin
            if (spi_cnt_q == '0) begin
               spi_cnt_d = SCW'(SPI_HALF - 1);
               sclk_d    = 1'b0;
               if (spi_bit_q == 3'd7) begin
                  spi_state_d = SPI_DEASSERT;
               end else begin
                  spi_state_d = SPI_LOW;
                  spi_bit_d   = spi_bit_q + 3'd1;
                  mosi_d      = mosi_sh_q[7];
                  mosi_sh_d   = {mosi_sh_q[6:0], 1'b0};
               end
            end else begin
               spi_cnt_d = spi_cnt_q - 1'b1;
            end
         end
         SPI_DEASSERT: begin
            if (spi_cnt_q == '0) begin
               spi_state_d = SPI_IDLE;
               cs_d        = 1'b1;
               mosi_d      = 1'b0;
            end else begin
               spi_cnt_d = spi_cnt_q - 1'b1;
            end
         end
         default: spi_state_d = SPI_IDLE;
      endcase
   end

   // SPI state and pin registers
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         spi_state_q <= SPI_IDLE;
         spi_cnt_q   <= '0;
         spi_bit_q   <= '0;
         mosi_sh_q   <= '0;
         miso_sh_q   <= '0;
         cs_q        <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         spi_state_q <= spi_state_d;
         spi_cnt_q   <= spi_cnt_d;
         spi_bit_q   <= spi_bit_d;
         mosi_sh_q   <= mosi_sh_d;
         miso_sh_q   <= miso_sh_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
      end
   end

   // Boot byte goes first; the flag drops once the trace transmitter takes it
   always_comb begin
      boot_pend_d = boot_pend_q && trace_busy;
      trace_req   = (boot_pend_q && !trace_busy) || spi_done;
      trace_data  = boot_pend_q ? BOOT_BYTE : miso_sh_q;
   end

   // Boot-pending flag, set by every reset
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) boot_pend_q <= 1'b1;
      else        boot_pend_q <= boot_pend_d;
   end

   soc_chip_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_host_tx (
      .clk   (clk_p),
      .rst_n (rst_n),
      .req   (accept),
      .data  (rx_sh_q),
      .txd   (tx_txd),
      .busy  (tx_busy)
   );

   soc_chip_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_trace_tx (
      .clk   (clk_p),
      .rst_n (rst_n),
      .req   (trace_req),
      .data  (trace_data),
      .txd   (trace_txd),
      .busy  (trace_busy)
   );

   assign io.txd       = tx_txd;
   assign io.trace_txd = trace_txd;
   assign io.spi_cs    = cs_q;
   assign io.spi_sclk  = sclk_q;
   assign io.spi_mosi  = mosi_q;
endmodule

// File: tb/tb_soc_chip_top.sv
// Scoreboard bench for soc_chip_top: directed host bytes, UART/SPI monitors
// that decode the pins and compare against queued expectations.
`timescale 1ns/1ps
module tb_soc_chip_top;
   localparam int BIT = 16;
   localparam int HALF = 4;

   logic clk = 1'b0;
   logic rst_top;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [7:0] exp_txd[$];
   logic [7:0] exp_trace[$];
   logic [7:0] exp_spi[$];

   soc_chip_top_if bus();

   assign bus.trace_rxd = 1'b1;
   assign bus.spi_miso  = bus.spi_cs ? 1'b1 : bus.spi_mosi;

   soc_chip_top #(.CLKS_PER_BIT(BIT), .SPI_HALF(HALF), .BOOT_BYTE(8'hA5)) dut (
      .clk_p   (clk),
      .clk_n   (~clk),
      .rst_top (rst_top),
      .io      (bus)
   );

   always #2.5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic uart_line(input bit tr);
      return tr ? bus.trace_txd : bus.txd;
   endfunction

   task automatic wait_cyc(input int n, inout bit ab);
      for (int i = 0; i < n; i++) begin
         if (ab) return;
         @(negedge clk);
         if (!rst_top) ab = 1'b1;
      end
   endtask

   task automatic mon_uart(input bit tr);
      logic [7:0] b;
      logic [7:0] e;
      logic       stop;
      bit         ab;
      string      nm;
      nm = tr ? "trace_txd" : "txd";
      forever begin
         @(negedge clk);
         if (rst_top && uart_line(tr) == 1'b0) begin
            ab = 1'b0;
            wait_cyc(BIT / 2, ab);
            if (!ab && uart_line(tr) == 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  wait_cyc(BIT, ab);
                  b[i] = uart_line(tr);
               end
               wait_cyc(BIT, ab);
               stop = uart_line(tr);
               if (!ab) begin
                  if ((tr ? exp_trace.size() : exp_txd.size()) == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL %s_unexpected: got frame 0x%02h, expected no frame", nm, b);
                  end else begin
                     e = tr ? exp_trace.pop_front() : exp_txd.pop_front();
                     check({nm, "_byte"}, {24'd0, b}, {24'd0, e});
                     check({nm, "_stop"}, {31'd0, stop}, 32'd1);
                  end
               end
            end
         end
      end
   endtask

   initial mon_uart(1'b0);
   initial mon_uart(1'b1);

   // SPI monitor: MOSI taken on each SCLK rise, high-phase length measured
   initial begin : spi_mon
      logic [7:0] got;
      logic [7:0] e;
      int         pulses, hi_len, cyc;
      bit         hi_ok, ab;
      logic       prev;
      forever begin
         @(negedge clk);
         if (rst_top && bus.spi_cs == 1'b0) begin
            got = '0; pulses = 0; hi_len = 0; hi_ok = 1'b1; ab = 1'b0; prev = 1'b0; cyc = 0;
            while (bus.spi_cs == 1'b0 && !ab && cyc < 1000) begin
               if (bus.spi_sclk && !prev) begin
                  got = {got[6:0], bus.spi_mosi};
                  pulses++;
                  hi_len = 0;
               end
               if (bus.spi_sclk) hi_len++;
               else if (prev && hi_len != HALF) hi_ok = 1'b0;
               prev = bus.spi_sclk;
               @(negedge clk);
               cyc++;
               if (!rst_top) ab = 1'b1;
            end
            if (cyc >= 1000) begin
               n_tests++;
               n_fail++;
               $display("FAIL spi_cs_timeout: got cs low 1000 cycles, expected release");
            end else if (!ab) begin
               if (exp_spi.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL spi_unexpected: got transfer 0x%02h, expected none", got);
               end else begin
                  e = exp_spi.pop_front();
                  check("spi_mosi_byte", {24'd0, got}, {24'd0, e});
                  check("spi_pulses", pulses, 8);
                  check("spi_sclk_high_len", {31'd0, hi_ok}, 32'd1);
                  check("spi_sclk_at_cs_rise", {30'd0, prev, bus.spi_sclk}, 32'd0);
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      bus.rxd = 1'b0;
      repeat (BIT) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         bus.rxd = b[i];
         repeat (BIT) @(posedge clk);
         #1;
      end
      bus.rxd = stop_bit;
      repeat (BIT) @(posedge clk);
      #1;
      bus.rxd = 1'b1;
   endtask

   task automatic expect_echo(input logic [7:0] b);
      exp_txd.push_back(b);
      exp_spi.push_back(b);
      exp_trace.push_back(b);
   endtask

   initial begin
      bus.rxd = 1'b1;
      rst_top = 1'b1;
      #1 rst_top = 1'b0;
      #99;
      check("rst_txd", {31'd0, bus.txd}, 32'd1);
      check("rst_trace_txd", {31'd0, bus.trace_txd}, 32'd1);
      check("rst_spi_cs", {31'd0, bus.spi_cs}, 32'd1);
      check("rst_spi_sclk", {31'd0, bus.spi_sclk}, 32'd0);
      check("rst_spi_mosi", {31'd0, bus.spi_mosi}, 32'd0);
      exp_trace.push_back(8'hA5);
      #31 rst_top = 1'b1;
      repeat (250) @(posedge clk);
      #1;

      // Echo
      expect_echo(8'h3C);
      send_byte(8'h3C, 1'b1);
      repeat (450) @(posedge clk);
      #1;

      // SPI timing pattern
      expect_echo(8'h81);
      send_byte(8'h81, 1'b1);
      repeat (450) @(posedge clk);
      #1;

      // Framing error: nothing expected anywhere
      send_byte(8'hFF, 1'b0);
      repeat (300) @(posedge clk);
      #1;

      // Second byte arrives while trace is still busy
      expect_echo(8'h11);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (500) @(posedge clk);
      #1;

      // Reset in the middle of an all-zero txd data field
      exp_spi.push_back(8'h00);
      send_byte(8'h00, 1'b1);
      repeat (100) @(posedge clk);
      #1;
      check("mid_txd_data_bit", {31'd0, bus.txd}, 32'd0);
      rst_top = 1'b0;
      #1;
      check("mid_rst_txd", {31'd0, bus.txd}, 32'd1);
      check("mid_rst_trace_txd", {31'd0, bus.trace_txd}, 32'd1);
      check("mid_rst_spi_cs", {31'd0, bus.spi_cs}, 32'd1);
      repeat (10) @(posedge clk);
      #1;
      exp_trace.push_back(8'hA5);
      rst_top = 1'b1;
      repeat (250) @(posedge clk);
      #1;

      check("left_exp_txd", exp_txd.size(), 0);
      check("left_exp_trace", exp_trace.size(), 0);
      check("left_exp_spi", exp_spi.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
